// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch controller.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_VALID,
      ST_HALT,
      ST_FAULT
   } state_t;

   localparam int unsigned INST_BYTES    = 4;
   localparam logic [63:0] DEF_RESET_PC  = 64'h0;
   localparam int unsigned DEF_MEM_WAIT  = 1;
   localparam int unsigned DEF_MEM_BYTES = 1024;

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch FSM: holds the PC on a combinational memory, samples after
// MEM_WAIT cycles, and hands words to decode. FETCH_HALT_ON_ZERO_EN stops on a zero word.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC  = DEF_RESET_PC,
   parameter int unsigned MEM_WAIT  = DEF_MEM_WAIT,
   parameter int unsigned MEM_BYTES = DEF_MEM_BYTES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [63:0] inst_pc,
   input  logic        br_valid,
   input  logic [63:0] br_target,
   output logic        halted,
   output logic        fault
);

   localparam logic [3:0]  WAIT_MAX  = 4'(MEM_WAIT);
   localparam logic [63:0] LAST_BYTE = 64'(MEM_BYTES - 1);
   localparam logic [63:0] PC_STEP   = 64'(INST_BYTES);

   state_t      state;
   logic [63:0] pc;
   logic [3:0]  cnt;
   logic        cnt_done;
   logic        bad_addr;
   logic        halt_word;

   assign imem_addr = pc;
   assign cnt_done  = (cnt == WAIT_MAX);
   assign bad_addr  = (pc[1:0] != 2'b00) || ((pc + 64'd3) > LAST_BYTE);

`ifdef FETCH_HALT_ON_ZERO_EN
   assign halt_word = (imem_data == 32'h0);
`else
   assign halt_word = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_WAIT;
         pc         <= RESET_PC;
         cnt        <= '0;
         inst_valid <= 1'b0;
         inst       <= '0;
         inst_pc    <= '0;
         halted     <= 1'b0;
         fault      <= 1'b0;
      end else if (br_valid && state != ST_FAULT) begin
         // redirect beats capture and transfer; a coincident transfer is simply consumed
         state      <= ST_WAIT;
         pc         <= br_target;
         cnt        <= '0;
         inst_valid <= 1'b0;
         halted     <= 1'b0;
      end else begin
         case (state)
            ST_WAIT: begin
               if (en) begin
                  if (cnt_done) begin
                     cnt <= '0;
                     if (bad_addr) begin
                        state <= ST_FAULT;
                        fault <= 1'b1;
                     end else if (halt_word) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                     end else begin
                        state      <= ST_VALID;
                        inst       <= imem_data;
                        inst_pc    <= pc;
                        pc         <= pc + PC_STEP;
                        inst_valid <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end
            end
            ST_VALID: begin
               // imem_addr already holds the next PC, so the wait overlaps the hold
               if (en && !cnt_done) cnt <= cnt + 4'd1;
               if (inst_ready) begin
                  state      <= ST_WAIT;
                  inst_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a byte-addressed little-endian memory model.
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [63:0] imem_addr;
   logic [31:0] imem_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        br_valid;
   logic [63:0] br_target;
   logic        halted;
   logic        fault;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0]  mem [0:1023];
   logic [9:0]  ma;
   logic [31:0] prog [4] = '{32'h8b1f03e5, 32'hf84000a4, 32'h8b040086, 32'hf80010a6};

   fetch_controller #(.RESET_PC(64'h0), .MEM_WAIT(1), .MEM_BYTES(1024)) dut (
      .clk(clk), .rst(rst), .en(en), .imem_addr(imem_addr), .imem_data(imem_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
      .br_valid(br_valid), .br_target(br_target), .halted(halted), .fault(fault)
   );

   always #5 clk = ~clk;

   assign ma = imem_addr[9:0];
   always_comb begin
      imem_data = 32'h0;
      if (imem_addr <= 64'd1020)
         imem_data = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put_word(input int a, input logic [31:0] w);
      for (int b = 0; b < 4; b++) mem[a + b] = w[8*b +: 8];
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_vld"}, 64'(inst_valid), 64'd0);
      chk({tag, "_inst"}, 64'(inst), 64'd0);
      chk({tag, "_ipc"}, inst_pc, 64'd0);
      chk({tag, "_addr"}, imem_addr, 64'd0);
      chk({tag, "_halt"}, 64'(halted), 64'd0);
      chk({tag, "_fault"}, 64'(fault), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      for (int i = 0; i < 4; i++) put_word(4 * i, prog[i]);
      put_word(1020, 32'hdeadbeef);

      rst = 1'b1; en = 1'b1; inst_ready = 1'b1; br_valid = 1'b0; br_target = '0;
      step(); step();
      rst = 1'b0;
      chk_reset("rst");

      // streaming: first word two edges after reset, then one every two cycles
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("stream_vld", 64'(inst_valid), 64'(k % 2 == 0));
         if (k % 2 == 0) begin
            chk("stream_inst", 64'(inst), 64'(prog[k/2 - 1]));
            chk("stream_ipc", inst_pc, 64'(4 * (k/2 - 1)));
         end
      end
      step();
      chk("pre16_vld", 64'(inst_valid), 64'd0);
      chk("pre16_addr", imem_addr, 64'd16);
      step();
`ifdef FETCH_HALT_ON_ZERO_EN
      chk("halt_flag", 64'(halted), 64'd1);
      chk("halt_vld", 64'(inst_valid), 64'd0);
      chk("halt_addr", imem_addr, 64'd16);
      step();
      chk("halt_hold", 64'(halted), 64'd1);
      chk("halt_addr2", imem_addr, 64'd16);
`else
      chk("zero_vld", 64'(inst_valid), 64'd1);
      chk("zero_inst", 64'(inst), 64'd0);
      chk("zero_ipc", inst_pc, 64'd16);
      chk("zero_halt", 64'(halted), 64'd0);
`endif

      // redirect to 0 restarts fetch
      br_valid = 1'b1; br_target = 64'd0;
      step();
      br_valid = 1'b0;
      chk("br0_vld", 64'(inst_valid), 64'd0);
      chk("br0_halt", 64'(halted), 64'd0);
      chk("br0_addr", imem_addr, 64'd0);
      step();
      chk("br0_wait", 64'(inst_valid), 64'd0);
      step();
      chk("br0_got", 64'(inst_valid), 64'd1);
      chk("br0_inst", 64'(inst), 64'(prog[0]));

      // decode stall holds the word
      inst_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("stall_vld", 64'(inst_valid), 64'd1);
         chk("stall_inst", 64'(inst), 64'(prog[0]));
         chk("stall_ipc", inst_pc, 64'd0);
         chk("stall_addr", imem_addr, 64'd4);
      end

      // redirect during VALID with a coincident transfer
      br_valid = 1'b1; br_target = 64'd8; inst_ready = 1'b1;
      step();
      br_valid = 1'b0;
      chk("br8_vld", 64'(inst_valid), 64'd0);
      chk("br8_addr", imem_addr, 64'd8);
      step();
      chk("br8_wait", 64'(inst_valid), 64'd0);
      step();
      chk("br8_got", 64'(inst_valid), 64'd1);
      chk("br8_inst", 64'(inst), 64'(prog[2]));
      chk("br8_ipc", inst_pc, 64'd8);
      step();
      chk("br8_nodup", 64'(inst_valid), 64'd0);
      step();
      chk("br8_next", 64'(inst), 64'(prog[3]));
      chk("br8_nipc", inst_pc, 64'd12);

      // reset in VALID with ready high
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_reset("rstv");

      // en low freezes the counter; reset mid-wait clears it
      en = 1'b0;
      step(); step();
      chk("en_frz", 64'(inst_valid), 64'd0);
      en = 1'b1;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_reset("rstw");
      step();
      chk("rstw_cnt", 64'(inst_valid), 64'd0);
      step();
      chk("rstw_got", 64'(inst_valid), 64'd1);
      chk("rstw_ipc", inst_pc, 64'd0);

      // misaligned target faults after the wait; redirect then ignored
      br_valid = 1'b1; br_target = 64'd6;
      step();
      br_valid = 1'b0;
      chk("mis_addr", imem_addr, 64'd6);
      step();
      chk("mis_early", 64'(fault), 64'd0);
      step();
      chk("mis_fault", 64'(fault), 64'd1);
      chk("mis_vld", 64'(inst_valid), 64'd0);
      br_valid = 1'b1; br_target = 64'd0;
      step();
      br_valid = 1'b0;
      chk("mis_sticky", 64'(fault), 64'd1);
      chk("mis_ignbr", imem_addr, 64'd6);
      chk("mis_vld2", 64'(inst_valid), 64'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mis_rstf", 64'(fault), 64'd0);
      chk("mis_rstpc", imem_addr, 64'd0);

      // last legal word, then the next one is out of range
      br_valid = 1'b1; br_target = 64'd1020;
      step();
      br_valid = 1'b0;
      step(); step();
      chk("top_vld", 64'(inst_valid), 64'd1);
      chk("top_inst", 64'(inst), 64'hdeadbeef);
      chk("top_ipc", inst_pc, 64'd1020);
      chk("top_addr", imem_addr, 64'd1024);
      step();
      chk("top_xfer", 64'(inst_valid), 64'd0);
      step();
      chk("oor_fault", 64'(fault), 64'd1);
      chk("oor_vld", 64'(inst_valid), 64'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;

      // top of the 64-bit space faults by range
      br_valid = 1'b1; br_target = 64'hffff_ffff_ffff_fffc;
      step();
      br_valid = 1'b0;
      step(); step();
      chk("wrap_fault", 64'(fault), 64'd1);
      chk("wrap_vld", 64'(inst_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
